tune_sequencer: RTL and testbench

- Programmable melody player that sits directly upstream of the piano tone generator and drives its note[3:0] and hush inputs.
- Steps through a 16-entry tune memory of (note, rest, duration, end) entries, timing each entry in beats derived from the 100 MHz clk.
- Inserts a short articulation gap (hush=1) at the end of every entry so that repeated notes are audibly separated.
- Supports one-shot and looping playback, plus stop at any time.

---
 rtl/tune_sequencer.sv | 164 ++++++++++++++++
 tb/tb_tune_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Melody sequencer feeding the piano tone generator: walks a 16-entry tune memory,
// times each entry in beats and forces a short silent gap at the end of every entry.
module tune_sequencer #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [9:0] wr_data,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] note,
  output logic       hush,
  output logic       busy,
  output logic [3:0] step
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickReload = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] GapLimit   = TickW'(GAP_CYCLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StPlay = 2'd2;

  // Tune memory: no reset, contents survive rst_n.
  logic [9:0] mem_q [16];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  logic [9:0] entry;
  assign entry = mem_q[step_q];

  logic [1:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [3:0]       beat_q, beat_d;
  logic [3:0]       cur_note_q, cur_note_d;
  logic             cur_rest_q, cur_rest_d;
  logic             cur_end_q, cur_end_d;
  logic [3:0]       note_q, note_d;
  logic             hush_q, hush_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_d     = tick_q;
    beat_d     = beat_q;
    cur_note_d = cur_note_q;
    cur_rest_d = cur_rest_q;
    cur_end_d  = cur_end_q;
    note_d     = note_q;
    hush_d     = hush_q;
    busy_d     = busy_q;

    unique case (state_q)
      StIdle: begin
        hush_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = StLoad;
          step_d  = 4'd0;
          busy_d  = 1'b1;
        end
      end

      StLoad: begin
        cur_note_d = entry[7:4];
        cur_rest_d = entry[8];
        cur_end_d  = entry[9];
        tick_d     = TickReload;
        beat_d     = entry[3:0];
        state_d    = StPlay;
        note_d     = entry[7:4];
        // GAP_CYCLES < TICK_DIV, so the first play cycle is never inside the gap.
        hush_d     = entry[8];
        busy_d     = 1'b1;
      end

      StPlay: begin
        busy_d = 1'b1;
        if ((tick_q == '0) && (beat_q == 4'd0)) begin
          hush_d = 1'b1;
          if (cur_end_q) begin
            if (loop) begin
              step_d  = 4'd0;
              state_d = StLoad;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            step_d  = step_q + 4'd1;
            state_d = StLoad;
          end
        end else begin
          if (tick_q == '0) begin
            beat_d = beat_q - 4'd1;
            tick_d = TickReload;
          end else begin
            tick_d = tick_q - 1'b1;
          end
          note_d = cur_note_q;
          hush_d = cur_rest_q | ((beat_d == 4'd0) && (tick_d < GapLimit));
        end
      end

      default: begin
        state_d = StIdle;
        hush_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Stop overrides everything, including a simultaneous start.
    if (stop) begin
      state_d = StIdle;
      step_d  = step_q;
      note_d  = note_q;
      hush_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      step_q     <= 4'd0;
      tick_q     <= '0;
      beat_q     <= 4'd0;
      cur_note_q <= 4'd0;
      cur_rest_q <= 1'b0;
      cur_end_q  <= 1'b0;
      note_q     <= 4'd0;
      hush_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tick_q     <= tick_d;
      beat_q     <= beat_d;
      cur_note_q <= cur_note_d;
      cur_rest_q <= cur_rest_d;
      cur_end_q  <= cur_end_d;
      note_q     <= note_d;
      hush_q     <= hush_d;
      busy_q     <= busy_d;
    end
  end

  assign note = note_q;
  assign hush = hush_q;
  assign busy = busy_q;
  assign step = step_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboard bench for tune_sequencer: the driver queues hand-computed per-cycle
// {note,hush,busy,step} vectors and a separate monitor pops and compares them.
module tb_tune_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned GC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [9:0] wr_data = 10'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] note;
  logic       hush;
  logic       busy;
  logic [3:0] step;

  logic       async_tick = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  int         scen = 0;
  logic [9:0] exp_q[$];
  int         tag_q[$];
  logic [9:0] mon_e, mon_a;
  int         mon_t;

  always #5 clk = ~clk;

  tune_sequencer #(
    .TICK_DIV  (TD),
    .GAP_CYCLES(GC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .stop   (stop),
    .loop   (loop),
    .note   (note),
    .hush   (hush),
    .busy   (busy),
    .step   (step)
  );

  function automatic logic [9:0] ev(input logic [3:0] n, input logic h, input logic b,
                                    input logic [3:0] s);
    return {n, h, b, s};
  endfunction

  // Monitor: one queued vector per clock edge (or per asynchronous check pulse).
  initial begin
    forever begin
      @(posedge clk or posedge async_tick);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_a = {note, hush, busy, step};
        n_vec++;
        if (mon_a !== mon_e) begin
          n_err++;
          $display("FAIL s%0d_vec%0d: got note=%h hush=%b busy=%b step=%h, want note=%h hush=%b busy=%b step=%h",
                   mon_t, n_vec, mon_a[9:6], mon_a[5], mon_a[4], mon_a[3:0],
                   mon_e[9:6], mon_e[5], mon_e[4], mon_e[3:0]);
        end
      end
    end
  end

  task automatic push(input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(scen);
  endtask

  task automatic cyc(input int n, input logic [9:0] e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      wr_en = 1'b0;
      push(e);
    end
  endtask

  task automatic pulse(input logic st, input logic sp, input logic [9:0] e);
    @(negedge clk);
    start = st;
    stop  = sp;
    wr_en = 1'b0;
    push(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d, input logic [9:0] e);
    @(negedge clk);
    start   = 1'b0;
    stop    = 1'b0;
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    push(e);
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    push(ev(4'h0, 1'b1, 1'b0, 4'h0));
    async_tick = 1'b1;
    #1;
    async_tick = 1'b0;
  endtask

  // Expected play-out of the 3-entry program, starting right after the LOAD of entry 0.
  task automatic prog_body();
    cyc(7, ev(4'h3, 1'b0, 1'b1, 4'h0));
    cyc(1, ev(4'h3, 1'b1, 1'b1, 4'h0));
    cyc(1, ev(4'h3, 1'b1, 1'b1, 4'h1));
    cyc(4, ev(4'h0, 1'b1, 1'b1, 4'h1));
    cyc(1, ev(4'h0, 1'b1, 1'b1, 4'h2));
    cyc(3, ev(4'hA, 1'b0, 1'b1, 4'h2));
    cyc(1, ev(4'hA, 1'b1, 1'b1, 4'h2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] iv;

    // 1: asynchronous reset before any clock edge
    scen = 1;
    #1;
    async_reset_check();
    cyc(2, ev(4'h0, 1'b1, 1'b0, 4'h0));
    rst_n = 1'b1;
    wr(4'd0, 10'h031, ev(4'h0, 1'b1, 1'b0, 4'h0));
    wr(4'd1, 10'h100, ev(4'h0, 1'b1, 1'b0, 4'h0));
    wr(4'd2, 10'h2A0, ev(4'h0, 1'b1, 1'b0, 4'h0));

    // 2: one-shot playback, busy high for 19 cycles
    scen = 2;
    pulse(1'b1, 1'b0, ev(4'h0, 1'b1, 1'b1, 4'h0));
    prog_body();
    cyc(3, ev(4'hA, 1'b1, 1'b0, 4'h2));

    // 3: looping playback for three passes, then stop during the loop-back LOAD
    scen = 3;
    loop = 1'b1;
    pulse(1'b1, 1'b0, ev(4'hA, 1'b1, 1'b1, 4'h0));
    for (int p = 0; p < 3; p++) begin
      prog_body();
      cyc(1, ev(4'hA, 1'b1, 1'b1, 4'h0));
    end
    pulse(1'b0, 1'b1, ev(4'hA, 1'b1, 1'b0, 4'h0));
    loop = 1'b0;
    cyc(1, ev(4'hA, 1'b1, 1'b0, 4'h0));

    // 4: start while busy ignored, stop mid-play, start+stop together from idle
    scen = 4;
    pulse(1'b1, 1'b0, ev(4'hA, 1'b1, 1'b1, 4'h0));
    cyc(1, ev(4'h3, 1'b0, 1'b1, 4'h0));
    pulse(1'b1, 1'b0, ev(4'h3, 1'b0, 1'b1, 4'h0));
    cyc(1, ev(4'h3, 1'b0, 1'b1, 4'h0));
    pulse(1'b0, 1'b1, ev(4'h3, 1'b1, 1'b0, 4'h0));
    cyc(1, ev(4'h3, 1'b1, 1'b0, 4'h0));
    pulse(1'b1, 1'b1, ev(4'h3, 1'b1, 1'b0, 4'h0));
    cyc(2, ev(4'h3, 1'b1, 1'b0, 4'h0));

    // 5: asynchronous reset mid-play, then the program replays from retained memory
    scen = 5;
    pulse(1'b1, 1'b0, ev(4'h3, 1'b1, 1'b1, 4'h0));
    cyc(4, ev(4'h3, 1'b0, 1'b1, 4'h0));
    @(posedge clk);
    #3;
    async_reset_check();
    cyc(2, ev(4'h0, 1'b1, 1'b0, 4'h0));
    rst_n = 1'b1;
    pulse(1'b1, 1'b0, ev(4'h0, 1'b1, 1'b1, 4'h0));
    prog_body();
    cyc(2, ev(4'hA, 1'b1, 1'b0, 4'h2));

    // 6: 16 one-beat notes 0..F, wrapping back to entry 0
    scen = 6;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      wr(iv, {2'b00, iv, 4'h0}, ev(4'hA, 1'b1, 1'b0, 4'h2));
    end
    pulse(1'b1, 1'b0, ev(4'hA, 1'b1, 1'b1, 4'h0));
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      cyc(3, ev(iv, 1'b0, 1'b1, iv));
      cyc(1, ev(iv, 1'b1, 1'b1, iv));
      cyc(1, ev(iv, 1'b1, 1'b1, iv + 4'd1));
    end
    cyc(1, ev(4'h0, 1'b0, 1'b1, 4'h0));
    pulse(1'b0, 1'b1, ev(4'h0, 1'b1, 1'b0, 4'h0));

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors still queued, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
